// File: rtl/cs_pkg.sv
// Shared types and constants for the CS window-average block and its BIST driver.
package cs_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 10;
  localparam int SUM_W = 12;
  localparam int ACC_W = SUM_W + 1;
  localparam int WIN   = 9;
  localparam int SIG_W = 16;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
  localparam logic [X_W-1:0]   LFSR_TAPS = 8'hB8;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_LFSR  = 2'b00,
    M_RAMP  = 2'b01,
    M_CONST = 2'b10,
    M_LFSR2 = 2'b11
  } mode_t;

  function automatic logic [X_W-1:0] lfsr_step(
    input logic [X_W-1:0] v
  );
    return {v[X_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0] s,
    input logic [Y_W-1:0]   y
  );
    return {s[SIG_W-2:0], 1'b0}
         ^ (s[SIG_W-1] ? MISR_POLY : '0)
         ^ {{(SIG_W-Y_W){1'b0}}, y};
  endfunction

endpackage

// File: rtl/cs_golden.sv
// Combinational golden model of the CS window average: 9 samples in, Y out.
module cs_golden
  import cs_pkg::*;
(
  input  logic [WIN*X_W-1:0] win_i,
  output logic [Y_W-1:0]     yg_o
);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] avg;
  logic [X_W-1:0]   xa;
  logic [ACC_W-1:0] acc;

  always_comb begin
    sum = '0;
    for (int i = 0; i < WIN; i++) begin
      sum = sum + SUM_W'(win_i[i*X_W +: X_W]);
    end
    avg = sum / SUM_W'(WIN);
    // the window minimum never exceeds the average, so xa is always found
    xa = '0;
    for (int i = 0; i < WIN; i++) begin
      if ((SUM_W'(win_i[i*X_W +: X_W]) <= avg) &&
          (win_i[i*X_W +: X_W] > xa)) begin
        xa = win_i[i*X_W +: X_W];
      end
    end
    acc  = ACC_W'(sum) + ACC_W'(xa) * ACC_W'(WIN);
    yg_o = Y_W'(acc >> 3);
  end

endmodule

// File: rtl/cs_bist_driver.sv
// Self-test stream source and checker for CS: drives X, checks Y against golden.
// Define CS_BIST_SIGNATURE_EN to add a 16-bit MISR signature port (sig).
module cs_bist_driver
  import cs_pkg::*;
#(
  parameter int             N_PAT   = 2000,
  parameter int             DUT_LAT = 1,
  parameter logic [X_W-1:0] SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [X_W-1:0]   X,
  input  logic [Y_W-1:0]   Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt
`ifdef CS_BIST_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0] sig
`endif
);

  localparam int IDX_W = $clog2(N_PAT);
  localparam int FC_W  = $clog2(DUT_LAT + 1);
  localparam int HIST  = WIN - 1;

  function automatic logic [X_W-1:0] first_sample(
    input mode_t m
  );
    logic [X_W-1:0] r;
    unique case (m)
      M_RAMP, M_CONST: r = SEED;
      default:         r = (SEED == '0) ? X_W'(1) : SEED;
    endcase
    return r;
  endfunction

  function automatic logic [X_W-1:0] next_sample(
    input mode_t          m,
    input logic [X_W-1:0] v
  );
    logic [X_W-1:0] r;
    unique case (m)
      M_RAMP:  r = v + X_W'(1);
      M_CONST: r = v;
      default: r = lfsr_step(v);
    endcase
    return r;
  endfunction

  state_t                       state_q, state_d;
  mode_t                        mode_q, mode_d;
  logic [X_W-1:0]               x_q, x_d;
  logic [HIST-1:0][X_W-1:0]     hist_q, hist_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [FC_W-1:0]              fc_q, fc_d;
  logic [DUT_LAT-1:0][Y_W-1:0]  ygl_q, ygl_d;
  logic [DUT_LAT-1:0]           vld_q, vld_d;
  logic [15:0]                  err_q, err_d;
`ifdef CS_BIST_SIGNATURE_EN
  logic [SIG_W-1:0]             sig_q, sig_d;
`endif

  logic [Y_W-1:0] yg;
  logic           cmp;
  logic           mis;

  // window for the sample currently on X: 8 previous samples plus X itself
  cs_golden u_golden (
    .win_i ({hist_q, x_q}),
    .yg_o  (yg)
  );

  assign cmp = vld_q[DUT_LAT-1];

  always_comb begin
    mis = 1'b0;
    // written as if/else so an unknown Y falls into the mismatch branch
    if (Y == ygl_q[DUT_LAT-1]) mis = 1'b0;
    else                       mis = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    hist_d  = hist_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    err_d   = err_q;
`ifdef CS_BIST_SIGNATURE_EN
    sig_d   = sig_q;
`endif

    ygl_d[0] = yg;
    vld_d[0] = (state_q == S_RUN);
    for (int i = 1; i < DUT_LAT; i++) begin
      ygl_d[i] = ygl_q[i-1];
      vld_d[i] = vld_q[i-1];
    end

    if (cmp) begin
      if (mis && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
`ifdef CS_BIST_SIGNATURE_EN
      sig_d = misr_step(sig_q, Y);
`endif
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          x_d     = first_sample(mode_t'(mode));
          idx_d   = '0;
          err_d   = '0;
`ifdef CS_BIST_SIGNATURE_EN
          sig_d   = '1;
`endif
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        hist_d = {hist_q[HIST-2:0], x_q};
        x_d    = next_sample(mode_q, x_q);
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(HIST - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        hist_d = {hist_q[HIST-2:0], x_q};
        if (idx_q == IDX_W'(N_PAT - 1)) begin
          fc_d    = '0;
          state_d = S_FLUSH;
        end else begin
          x_d   = next_sample(mode_q, x_q);
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_FLUSH: begin
        fc_d = fc_q + FC_W'(1);
        if (fc_q == FC_W'(DUT_LAT - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_LFSR;
      x_q     <= '0;
      hist_q  <= '0;
      idx_q   <= '0;
      fc_q    <= '0;
      ygl_q   <= '0;
      vld_q   <= '0;
      err_q   <= '0;
`ifdef CS_BIST_SIGNATURE_EN
      sig_q   <= '1;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      hist_q  <= hist_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      ygl_q   <= ygl_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
`ifdef CS_BIST_SIGNATURE_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign X       = x_q;
  assign busy    = (state_q == S_FILL) || (state_q == S_RUN) ||
                   (state_q == S_FLUSH);
  assign done    = (state_q == S_DONE);
  assign pass    = (state_q == S_DONE) && (err_q == '0);
  assign err_cnt = err_q;
`ifdef CS_BIST_SIGNATURE_EN
  assign sig     = sig_q;
`endif

endmodule

// File: tb/tb_cs_bist_driver.sv
// Directed bench for cs_bist_driver: ramp table, constant, LFSR loopback, resets.
module tb_cs_bist_driver;

  logic clk;
  logic reset;

  logic       start_a, start_b, start_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [7:0] x_a, x_b, x_c;
  logic [9:0] y_a, y_b, y_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c;
  logic [15:0] err_a, err_b, err_c;
`ifdef CS_BIST_SIGNATURE_EN
  logic [15:0] sig_a, sig_b, sig_c;
`endif

  logic              flip_c;
  logic [10:0][7:0]  xh_c;

  int errors;
  int checks;

  cs_bist_driver #(.N_PAT(20), .DUT_LAT(1), .SEED(8'h01)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
    .X(x_a), .Y(y_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a)
`ifdef CS_BIST_SIGNATURE_EN
    , .sig(sig_a)
`endif
  );

  cs_bist_driver #(.N_PAT(20), .DUT_LAT(3), .SEED(8'hFF)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
    .X(x_b), .Y(y_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b)
`ifdef CS_BIST_SIGNATURE_EN
    , .sig(sig_b)
`endif
  );

  cs_bist_driver #(.N_PAT(2000), .DUT_LAT(2), .SEED(8'hA5)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .mode(mode_c),
    .X(x_c), .Y(y_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_cnt(err_c)
`ifdef CS_BIST_SIGNATURE_EN
    , .sig(sig_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ref_y(input logic [71:0] w);
    int s, a, xa, v;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(w[i*8 +: 8]);
    a  = s / 9;
    xa = 0;
    for (int i = 0; i < 9; i++) begin
      v = int'(w[i*8 +: 8]);
      if (v <= a && v > xa) xa = v;
    end
    return 10'((s + 9 * xa) / 8);
  endfunction

  // behavioural CS with 2-cycle latency looped back onto instance c
  always @(negedge clk) xh_c <= {xh_c[9:0], x_c};
  assign y_c = ref_y(xh_c[10:2]) ^ {9'b0, flip_c};

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({x_a, busy_a, done_a, pass_a, err_a} !== 27'd0) begin
      errors++;
      $display("FAIL reset_a got x=%h b=%b d=%b p=%b e=%0d want 0",
               x_a, busy_a, done_a, pass_a, err_a);
    end
    checks++;
    if ({x_b, busy_b, done_b, pass_b, err_b} !== 27'd0) begin
      errors++;
      $display("FAIL reset_b got x=%h b=%b d=%b p=%b e=%0d want 0",
               x_b, busy_b, done_b, pass_b, err_b);
    end
    checks++;
    if ({x_c, busy_c, done_c, pass_c, err_c} !== 27'd0) begin
      errors++;
      $display("FAIL reset_c got x=%h b=%b d=%b p=%b e=%0d want 0",
               x_c, busy_c, done_c, pass_c, err_c);
    end
`ifdef CS_BIST_SIGNATURE_EN
    checks++;
    if (sig_a !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_sig got=%h want=ffff", sig_a);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    logic [9:0]  tab [12];
    logic [7:0]  exp_x;
    logic        exp_busy, exp_done;
    logic [15:0] m;
    tab = '{10'd11, 10'd13, 10'd15, 10'd18, 10'd20, 10'd22,
            10'd24, 10'd27, 10'd29, 10'd31, 10'd33, 10'd36};
    mode_a = 2'b01;
    y_a    = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 0; n <= 22; n++) begin
      y_a = (n >= 9 && n <= 20) ? tab[n-9] : 10'd0;
      exp_x    = (n < 20) ? 8'(n + 1) : 8'd20;
      exp_busy = (n <= 20);
      exp_done = (n >= 21);
      checks++;
      if (x_a !== exp_x) begin
        errors++;
        $display("FAIL ramp_x n=%0d got=%h want=%h", n, x_a, exp_x);
      end
      checks++;
      if ({busy_a, done_a} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL ramp_state n=%0d got busy=%b done=%b want %b %b",
                 n, busy_a, done_a, exp_busy, exp_done);
      end
      @(negedge clk);
    end
    checks++;
    if ({pass_a, err_a} !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL ramp_result got pass=%b err=%0d want pass=1 err=0",
               pass_a, err_a);
    end
    m = 16'hFFFF;
    for (int j = 0; j < 12; j++) begin
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0) ^ {6'b0, tab[j]};
    end
`ifdef CS_BIST_SIGNATURE_EN
    checks++;
    if (sig_a !== m) begin
      errors++;
      $display("FAIL ramp_sig got=%h want=%h", sig_a, m);
    end
`endif
  endtask

  task automatic test_const();
    logic [15:0] m;
    mode_b = 2'b10;
    for (int r = 0; r < 2; r++) begin
      y_b = (r == 0) ? 10'h23D : 10'h000;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      checks++;
      if ({done_b, pass_b, err_b} !== 18'd0) begin
        errors++;
        $display("FAIL const_clear r=%0d got d=%b p=%b e=%0d want 0",
                 r, done_b, pass_b, err_b);
      end
      for (int n = 0; n <= 24; n++) begin
        checks++;
        if (x_b !== 8'hFF) begin
          errors++;
          $display("FAIL const_x n=%0d got=%h want=ff", n, x_b);
        end
        checks++;
        if (done_b !== (n >= 23)) begin
          errors++;
          $display("FAIL const_done n=%0d got=%b want=%b",
                   n, done_b, (n >= 23));
        end
        @(negedge clk);
      end
      checks++;
      if (err_b !== ((r == 0) ? 16'd0 : 16'd12)) begin
        errors++;
        $display("FAIL const_err r=%0d got=%0d want=%0d",
                 r, err_b, (r == 0) ? 0 : 12);
      end
      checks++;
      if (pass_b !== (r == 0)) begin
        errors++;
        $display("FAIL const_pass r=%0d got=%b want=%b", r, pass_b, (r == 0));
      end
      if (r == 0) begin
        m = 16'hFFFF;
        for (int j = 0; j < 12; j++) begin
          m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0) ^ 16'h023D;
        end
`ifdef CS_BIST_SIGNATURE_EN
        checks++;
        if (sig_b !== m) begin
          errors++;
          $display("FAIL const_sig got=%h want=%h", sig_b, m);
        end
`endif
      end
    end
  endtask

  task automatic test_lfsr(input bit do_flip);
    mode_c  = 2'b00;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int n = 0; n <= 2003; n++) begin
      if (n == 0) begin
        checks++;
        if (x_c !== 8'hA5) begin
          errors++;
          $display("FAIL lfsr_first got=%h want=a5", x_c);
        end
      end
      if (n == 500 && do_flip) begin
        #1 flip_c = 1'b1;
      end
      if (n == 501) begin
        #1 flip_c = 1'b0;
      end
      if (n == 2001) begin
        checks++;
        if ({busy_c, done_c} !== 2'b10) begin
          errors++;
          $display("FAIL lfsr_busy n=2001 got busy=%b done=%b want 1 0",
                   busy_c, done_c);
        end
      end
      if (n == 2002) begin
        checks++;
        if ({busy_c, done_c} !== 2'b01) begin
          errors++;
          $display("FAIL lfsr_done n=2002 got busy=%b done=%b want 0 1",
                   busy_c, done_c);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (err_c !== (do_flip ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL lfsr_err flip=%0d got=%0d want=%0d",
               do_flip, err_c, do_flip ? 1 : 0);
    end
    checks++;
    if (pass_c !== !do_flip) begin
      errors++;
      $display("FAIL lfsr_pass flip=%0d got=%b want=%b",
               do_flip, pass_c, !do_flip);
    end
  endtask

  task automatic test_reset_midrun();
    mode_c  = 2'b00;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int n = 0; n < 10; n++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({x_c, busy_c, done_c, pass_c, err_c} !== 27'd0) begin
      errors++;
      $display("FAIL midrst_c got x=%h b=%b d=%b p=%b e=%0d want 0",
               x_c, busy_c, done_c, pass_c, err_c);
    end
    checks++;
    if ({done_a, pass_a, done_b} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_others got da=%b pa=%b db=%b want 0",
               done_a, pass_a, done_b);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) @(negedge clk);
    checks++;
    if ({busy_c, done_c} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle got busy=%b done=%b want 0 0",
               busy_c, done_c);
    end
  endtask

  task automatic test_back_to_back();
    mode_c  = 2'b00;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int n = 0; n <= 2003; n++) begin
      if (n == 100 || n == 1500 || n == 2001) begin
        mode_c  = 2'b01;
        start_c = 1'b1;
      end else begin
        start_c = 1'b0;
      end
      if (n == 2001) begin
        checks++;
        if ({busy_c, done_c} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_busy n=2001 got busy=%b done=%b want 1 0",
                   busy_c, done_c);
        end
      end
      if (n == 2002) begin
        checks++;
        if ({busy_c, done_c} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_done n=2002 got busy=%b done=%b want 0 1",
                   busy_c, done_c);
        end
      end
      @(negedge clk);
    end
    start_c = 1'b0;
    checks++;
    if ({pass_c, err_c} !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL b2b_result got pass=%b err=%0d want pass=1 err=0",
               pass_c, err_c);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a  = 2'b00; mode_b = 2'b00; mode_c = 2'b00;
    y_a     = '0;
    y_b     = '0;
    flip_c  = 1'b0;

    test_reset();
    test_ramp();
    test_const();
    test_lfsr(1'b0);
    test_lfsr(1'b1);
    test_reset_midrun();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
